pci_bus_monitor: RTL

Passive, cycle-accurate tracker of PCI bus phases, and the parametrised successor of the team's basic PCI phase state machine. It samples the active-low bus control lines every clock and reports the current phase. It adds several things the basic machine lacks: target STOP handling, master-abort detection on DEVSEL timeout, turnaround and fast back-to-back tracking, and per-transaction data-phase and wait-state counters. It sits beside the controller and feeds the arbiter, performance counters and error logic. It never drives the bus.

---
 rtl/pci_bus_monitor.sv | 117 +++++++++++
 1 files changed

// File: rtl/pci_bus_monitor.sv
// Passive PCI phase tracker with DEVSEL timeout, STOP, turnaround and per-transaction counters.
// All outputs registered, one clock after the sampled bus condition; never drives the bus, so no backpressure.
module pci_bus_monitor #(
  parameter int CNT_W          = 8,
  parameter int WAIT_W         = 4,
  parameter int DEVSEL_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_n,
  input  logic              irdy_n,
  input  logic              trdy_n,
  input  logic              devsel_n,
  input  logic              stop_n,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  data_count,
  output logic [WAIT_W-1:0] wait_count,
  output logic              xfer_done,
  output logic              target_stop,
  output logic              master_abort,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WAIT    = 3'd2,
    S_DATA    = 3'd3,
    S_FINAL   = 3'd4,
    S_TURN    = 3'd5,
    S_ABORT   = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [3:0]        TMO_LAST = 4'(DEVSEL_TIMEOUT - 1);

  state_t     cur;
  state_t     nxt;
  logic       devsel_seen;
  logic [3:0] timer;
  logic       active;
  logic       xfer;
  logic       stop;
  logic       timeout;
  logic       stop_pulse;

  assign state = cur;

  always_comb begin
    nxt        = cur;
    stop_pulse = 1'b0;
    active     = (cur == S_WAIT) || (cur == S_DATA);
    xfer       = active & ~irdy_n & ~trdy_n & ~devsel_n;
    stop       = active & ~stop_n & ~devsel_n;
    timeout    = active & ~devsel_seen & devsel_n & (timer == TMO_LAST);
    case (cur)
      S_IDLE: if (!frame_n) nxt = S_ADDR;
      S_ADDR: nxt = S_WAIT;
      S_WAIT, S_DATA: begin
        // A final-phase transfer outranks STOP, so target_stop stays low then.
        if (timeout) begin
          nxt = S_ABORT;
        end else if (xfer && frame_n) begin
          nxt = S_TURN;
        end else if (stop) begin
          nxt        = frame_n ? S_TURN : S_FINAL;
          stop_pulse = 1'b1;
        end else if (xfer) begin
          nxt = S_DATA;
        end else begin
          nxt = S_WAIT;
        end
      end
      S_FINAL, S_ABORT: if (frame_n && irdy_n) nxt = S_TURN;
      S_TURN: nxt = frame_n ? S_IDLE : S_ADDR;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur          <= S_IDLE;
      data_count   <= '0;
      wait_count   <= '0;
      xfer_done    <= 1'b0;
      target_stop  <= 1'b0;
      master_abort <= 1'b0;
      busy         <= 1'b0;
      devsel_seen  <= 1'b0;
      timer        <= '0;
    end else begin
      cur          <= nxt;
      busy         <= (nxt != S_IDLE);
      xfer_done    <= xfer;
      target_stop  <= stop_pulse;
      master_abort <= timeout;
      if (cur == S_ADDR) begin
        data_count  <= '0;
        wait_count  <= '0;
        timer       <= '0;
        devsel_seen <= 1'b0;
      end else if (active) begin
        if (!devsel_n) devsel_seen <= 1'b1;
        if (!devsel_seen && devsel_n) timer <= timer + 4'd1;
        if (xfer) begin
          if (data_count != CNT_MAX) data_count <= data_count + 1'b1;
          wait_count <= '0;
        end else if (wait_count != WAIT_MAX) begin
          wait_count <= wait_count + 1'b1;
        end
      end
    end
  end

endmodule
